// File: rtl/dau_symbol_tx_buffer_if.sv
// Symbol-in / byte-out bus of the DAU symbol transmit buffer, plus the shared
// symbol encoding used by the formatter side.
`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 5
`endif
`ifndef DAU_SYM_MINUS
`define DAU_SYM_MINUS 5'h1A
`endif
`ifndef DAU_SYM_COMMA
`define DAU_SYM_COMMA 5'h1B
`endif
`ifndef DAU_SYM_INVALID
`define DAU_SYM_INVALID 5'h1F
`endif

interface dau_symbol_tx_buffer_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   // Byte side: a byte moves on every cycle where o_tx_valid && i_tx_ready;
   // o_tx_data is only meaningful while o_tx_valid is high.
   logic [`DAU_SYM_WIDTH-1:0] i_symbol;
   logic                      i_symbol_valid;
   logic                      i_stream_done;
   logic [7:0]                o_tx_data;
   logic                      o_tx_valid;
   logic                      i_tx_ready;
   logic [LW-1:0]             o_level;
   logic                      o_overflow;
   logic                      i_clr_overflow;
   logic                      o_busy;
   logic [1:0]                o_eol_state;

   modport slave (
      input  i_symbol, i_symbol_valid, i_stream_done, i_tx_ready, i_clr_overflow,
      output o_tx_data, o_tx_valid, o_level, o_overflow, o_busy, o_eol_state
   );

   modport master (
      output i_symbol, i_symbol_valid, i_stream_done, i_tx_ready, i_clr_overflow,
      input  o_tx_data, o_tx_valid, o_level, o_overflow, o_busy, o_eol_state
   );
endinterface

// File: rtl/dau_symbol_tx_buffer.sv
// Maps formatter symbols to ASCII, appends CR LF per result, and buffers the
// bytes in a first-word-fall-through FIFO toward the UART transmitter.
module dau_symbol_tx_buffer #(
   parameter int         FIFO_DEPTH = 16,
   parameter bit         EOL_EN     = 1'b1,
   parameter logic [7:0] SUB_CHAR   = 8'h3F
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   dau_symbol_tx_buffer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = `DAU_SYM_WIDTH;

   typedef enum logic [1:0] {
      EOL_IDLE = 2'd0,
      EOL_CR   = 2'd1,
      EOL_LF   = 2'd2,
      EOL_HOLD = 2'd3
   } eol_state_t;

   eol_state_t    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          done_q, done_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic       tx_valid;
   logic       pop;
   logic       space;
   logic       sym_push;
   logic       eol_push;
   logic       push;
   logic [7:0] sym_byte;
   logic [7:0] eol_byte;
   logic [7:0] push_byte;

   // Digits are encoded with all-ones upper bits and the value in the low nibble.
   always_comb begin
      sym_byte = SUB_CHAR;
      if ((&bus.i_symbol[SW-1:4]) && (bus.i_symbol[3:0] <= 4'd9)) begin
         sym_byte = 8'h30 + {4'h0, bus.i_symbol[3:0]};
      end else if (bus.i_symbol == `DAU_SYM_MINUS) begin
         sym_byte = 8'h2D;
      end else if (bus.i_symbol == `DAU_SYM_COMMA) begin
         sym_byte = 8'h2C;
      end
   end

   always_comb begin
      tx_valid   = (level_q != '0);
      pop        = tx_valid && bus.i_tx_ready;
      // A pop in the same cycle frees the slot even when full.
      space      = (level_q < LW'(FIFO_DEPTH)) || pop;
      sym_push   = bus.i_symbol_valid && space;
      done_d     = bus.i_stream_done;
      state_d    = state_q;
      eol_push   = 1'b0;
      eol_byte   = 8'h0D;

      case (state_q)
         EOL_IDLE: begin
            if (EOL_EN && bus.i_stream_done && !done_q) state_d = EOL_CR;
         end
         EOL_CR: begin
            if (!bus.i_symbol_valid && space) begin
               eol_push = 1'b1;
               state_d  = EOL_LF;
            end
         end
         EOL_LF: begin
            eol_byte = 8'h0A;
            if (!bus.i_symbol_valid && space) begin
               eol_push = 1'b1;
               state_d  = EOL_HOLD;
            end
         end
         EOL_HOLD: begin
            if (!bus.i_stream_done) state_d = EOL_IDLE;
         end
         default: state_d = EOL_IDLE;
      endcase

      push      = sym_push || eol_push;
      push_byte = bus.i_symbol_valid ? sym_byte : eol_byte;
      wr_ptr_d  = push ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d  = pop ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
      level_d   = level_q + LW'(push) - LW'(pop);

      // A drop in the same cycle as a clear keeps the flag set.
      overflow_d = overflow_q;
      if (bus.i_clr_overflow) overflow_d = 1'b0;
      if (bus.i_symbol_valid && !space) overflow_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= EOL_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= push_byte;
   end

   assign bus.o_tx_valid  = tx_valid;
   assign bus.o_tx_data   = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign bus.o_level     = level_q;
   assign bus.o_overflow  = overflow_q;
   assign bus.o_busy      = tx_valid || (state_q == EOL_CR) || (state_q == EOL_LF);
   assign bus.o_eol_state = state_q;
endmodule

// File: tb/tb_dau_symbol_tx_buffer.sv
// Directed bench for dau_symbol_tx_buffer: expected bytes are queued as
// symbols are driven and compared as the transmitter side accepts them.
module tb_dau_symbol_tx_buffer;
  localparam int DEPTH = 16;
  localparam logic [4:0] S_MINUS = 5'h1A;
  localparam logic [4:0] S_COMMA = 5'h1B;
  localparam logic [4:0] S_INV   = 5'h1F;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CR   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [7:0] exp_q[$];

  dau_symbol_tx_buffer_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

  dau_symbol_tx_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle; the byte handshake is scored at the falling edge
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (bus_if.o_tx_valid && bus_if.i_tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", bus_if.o_tx_data, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sym(input logic [4:0] sym, input logic [7:0] exp_b, input bit accept);
    bus_if.i_symbol       = sym;
    bus_if.i_symbol_valid = 1'b1;
    if (accept) exp_q.push_back(exp_b);
    tick();
    bus_if.i_symbol_valid = 1'b0;
  endtask

  task automatic drain();
    bus_if.i_tx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && bus_if.o_level == 0) break;
      tick();
    end
    chk("drain_sb_empty", exp_q.size(), 0);
    chk("drain_level", bus_if.o_level, 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.i_symbol       = '0;
    bus_if.i_symbol_valid = 1'b0;
    bus_if.i_stream_done  = 1'b0;
    bus_if.i_tx_ready     = 1'b0;
    bus_if.i_clr_overflow = 1'b0;
    repeat (3) tick();
    chk("rst_tx_valid", bus_if.o_tx_valid, 0);
    chk("rst_tx_data", bus_if.o_tx_data, 8'h00);
    chk("rst_level", bus_if.o_level, 0);
    chk("rst_overflow", bus_if.o_overflow, 0);
    chk("rst_busy", bus_if.o_busy, 0);
    chk("rst_state", bus_if.o_eol_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // reset asserted mid-stream with five bytes queued
    for (int i = 1; i <= 5; i++) drive_sym(5'h10 | 5'(i), 8'h30 + 8'(i), 1'b1);
    chk("mid_level5", bus_if.o_level, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", bus_if.o_tx_valid, 0);
    chk("midrst_level", bus_if.o_level, 0);
    chk("midrst_overflow", bus_if.o_overflow, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    drive_sym(5'h13, 8'h33, 1'b1);
    chk("lat1_valid", bus_if.o_tx_valid, 1);
    chk("lat1_data", bus_if.o_tx_data, 8'h33);
    drain();

    // stream "-12,5" with CR LF appended
    bus_if.i_tx_ready = 1'b1;
    drive_sym(S_MINUS, 8'h2D, 1'b1);
    drive_sym(5'h11, 8'h31, 1'b1);
    drive_sym(5'h12, 8'h32, 1'b1);
    drive_sym(S_COMMA, 8'h2C, 1'b1);
    bus_if.i_stream_done = 1'b1;
    drive_sym(5'h15, 8'h35, 1'b1);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    chk("stream_state_cr", bus_if.o_eol_state, ST_CR);
    repeat (3) tick();
    bus_if.i_stream_done = 1'b0;
    drain();
    tick();
    chk("stream_busy_low", bus_if.o_busy, 0);
    chk("stream_state_idle", bus_if.o_eol_state, ST_IDLE);

    // backpressure
    bus_if.i_tx_ready = 1'b0;
    drive_sym(5'h17, 8'h37, 1'b1);
    drive_sym(5'h18, 8'h38, 1'b1);
    drive_sym(5'h19, 8'h39, 1'b1);
    drive_sym(5'h10, 8'h30, 1'b1);
    chk("bp_level4", bus_if.o_level, 4);
    repeat (2) tick();
    chk("bp_head_held", bus_if.o_tx_data, 8'h37);
    bus_if.i_tx_ready = 1'b1;
    tick();
    chk("bp_level3", bus_if.o_level, 3);
    chk("bp_head_next", bus_if.o_tx_data, 8'h38);
    drain();

    // overflow: 17 pushes into a 16-entry FIFO
    bus_if.i_tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive_sym(5'h17, 8'h37, 1'b1);
    chk("ovf_before", bus_if.o_overflow, 0);
    drive_sym(5'h17, 8'h37, 1'b0);
    chk("ovf_level16", bus_if.o_level, DEPTH);
    chk("ovf_set", bus_if.o_overflow, 1);
    bus_if.i_clr_overflow = 1'b1;
    tick();
    bus_if.i_clr_overflow = 1'b0;
    chk("ovf_cleared", bus_if.o_overflow, 0);
    bus_if.i_clr_overflow = 1'b1;
    drive_sym(5'h17, 8'h37, 1'b0);
    bus_if.i_clr_overflow = 1'b0;
    chk("ovf_set_wins", bus_if.o_overflow, 1);
    bus_if.i_clr_overflow = 1'b1;
    tick();
    bus_if.i_clr_overflow = 1'b0;

    // push and pop together while full
    bus_if.i_tx_ready = 1'b1;
    drive_sym(5'h14, 8'h34, 1'b1);
    bus_if.i_tx_ready = 1'b0;
    chk("full_pp_level", bus_if.o_level, DEPTH);
    chk("full_pp_no_ovf", bus_if.o_overflow, 0);

    // EOL stalls while full
    bus_if.i_stream_done = 1'b1;
    tick();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    chk("stall_state_cr", bus_if.o_eol_state, ST_CR);
    repeat (3) tick();
    chk("stall_still_cr", bus_if.o_eol_state, ST_CR);
    chk("stall_busy", bus_if.o_busy, 1);
    chk("stall_level", bus_if.o_level, DEPTH);
    bus_if.i_tx_ready = 1'b1;
    repeat (2) tick();
    bus_if.i_tx_ready = 1'b0;
    chk("stall_level_after", bus_if.o_level, DEPTH);
    chk("stall_state_hold", bus_if.o_eol_state, ST_HOLD);
    chk("stall_no_ovf", bus_if.o_overflow, 0);
    bus_if.i_stream_done = 1'b0;
    tick();
    chk("stall_idle", bus_if.o_eol_state, ST_IDLE);
    drain();

    // mapping corners
    bus_if.i_tx_ready = 1'b0;
    drive_sym(5'h00, 8'h3F, 1'b1);
    chk("unmapped_head", bus_if.o_tx_data, 8'h3F);
    drive_sym(S_INV, 8'h3F, 1'b1);
    drive_sym(5'h1C, 8'h3F, 1'b1);
    drive_sym(5'h10, 8'h30, 1'b1);
    drive_sym(5'h19, 8'h39, 1'b1);
    drive_sym(5'h0A, 8'h3F, 1'b1);
    drain();
    tick();
    chk("final_busy", bus_if.o_busy, 0);
    chk("final_ovf", bus_if.o_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
